// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the sequence-detector family:
// FSM state encodings and the word-width limit that sizes the bit counter.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } seq_state_t;

    localparam int SEQ_MAX_WIDTH = 32;
    localparam int SEQ_CNT_W     = $clog2(SEQ_MAX_WIDTH);

endpackage

// File: rtl/seq_bit_cnt.sv
// Bits-remaining down-counter: loads WIDTH-1 when a word starts and counts to zero.
// last flags the final data bit; almost_last flags the bit before it.
module seq_bit_cnt
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last,
    output logic almost_last
);

    logic [SEQ_CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= SEQ_CNT_W'(WIDTH - 1);
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - SEQ_CNT_W'(1);
        end
    end

    assign last        = (count_reg == '0);
    assign almost_last = (count_reg == SEQ_CNT_W'(1));

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder (MSB first) with zero-bubble back-to-back reload.
// Define SEQ_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

`ifdef SEQ_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    seq_state_t       state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic             x_reg;
    logic             x_valid_reg;
    logic             word_done_reg;
`ifdef SEQ_SERIALIZER_PARITY_EN
    logic             parity_reg;
`endif
    logic             cnt_last;
    logic             cnt_almost;
    logic             accept;

    seq_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .load        (accept),
        .en          (state_reg == ST_SHIFT),
        .last        (cnt_last),
        .almost_last (cnt_almost)
    );

    // Ready opens during the final bit so the next word's MSB follows with no gap.
`ifdef SEQ_SERIALIZER_PARITY_EN
    assign din_ready = (state_reg == ST_IDLE) || (state_reg == ST_PARITY);
`else
    assign din_ready = (state_reg == ST_IDLE) || ((state_reg == ST_SHIFT) && cnt_last);
`endif
    assign accept = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            x_reg         <= 1'b0;
            x_valid_reg   <= 1'b0;
            word_done_reg <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity_reg    <= 1'b0;
`endif
        end else if (accept) begin
            // The MSB goes straight to x; the shift register holds the rest of the word.
            state_reg     <= ST_SHIFT;
            x_reg         <= din[WIDTH-1];
            x_valid_reg   <= 1'b1;
            shift_reg     <= din << 1;
            word_done_reg <= !PARITY_EN && (WIDTH == 1);
`ifdef SEQ_SERIALIZER_PARITY_EN
            parity_reg    <= ^din;
`endif
        end else begin
            case (state_reg)
                ST_SHIFT: begin
                    if (!cnt_last) begin
                        x_reg         <= shift_reg[WIDTH-1];
                        shift_reg     <= shift_reg << 1;
                        word_done_reg <= !PARITY_EN && cnt_almost;
                    end else begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                        state_reg     <= ST_PARITY;
                        x_reg         <= parity_reg;
                        word_done_reg <= 1'b1;
`else
                        state_reg     <= ST_IDLE;
                        shift_reg     <= '0;
                        x_reg         <= 1'b0;
                        x_valid_reg   <= 1'b0;
                        word_done_reg <= 1'b0;
`endif
                    end
                end
                ST_PARITY: begin
                    state_reg     <= ST_IDLE;
                    shift_reg     <= '0;
                    x_reg         <= 1'b0;
                    x_valid_reg   <= 1'b0;
                    word_done_reg <= 1'b0;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    x_reg         <= 1'b0;
                    x_valid_reg   <= 1'b0;
                    word_done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign x         = x_reg;
    assign x_valid   = x_valid_reg;
    assign word_done = word_done_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: accepted words push their expected bit stream,
// the negedge monitor pops and compares every cycle (honours SEQ_SERIALIZER_PARITY_EN).
module tb_seq_bit_serializer;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic bit_v;
        logic done;
    } exp_bit_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             word_done;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;
    exp_bit_t exp_q[$];

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .x         (x),
        .x_valid   (x_valid),
        .word_done (word_done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard producer: an accepted word becomes its expected bit stream.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (din_valid && din_ready) begin
            logic [WIDTH-1:0] w;
            w = din;
            for (int i = WIDTH - 1; i >= 0; i--) begin
`ifdef SEQ_SERIALIZER_PARITY_EN
                exp_q.push_back('{bit_v: w[i], done: 1'b0});
`else
                exp_q.push_back('{bit_v: w[i], done: (i == 0)});
`endif
            end
`ifdef SEQ_SERIALIZER_PARITY_EN
            exp_q.push_back('{bit_v: ^w, done: 1'b1});
`endif
            $display("accept din=%02h at %0t", w, $time);
        end
    end

    // Monitor: one expected bit per cycle while the queue holds one, idle outputs otherwise.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (exp_q.size() > 0) begin
                exp_bit_t e;
                e = exp_q.pop_front();
                check("x_valid", 32'(x_valid), 32'd1);
                check("busy", 32'(busy), 32'd1);
                check("x", 32'(x), 32'(e.bit_v));
                check("word_done", 32'(word_done), 32'(e.done));
                check("din_ready", 32'(din_ready), 32'(e.done));
            end else begin
                check("idle_x_valid", 32'(x_valid), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_x", 32'(x), 32'd0);
                check("idle_word_done", 32'(word_done), 32'd0);
                check("idle_din_ready", 32'(din_ready), 32'd1);
            end
        end
    end

    // Offers w until accepted; hold keeps din_valid high for a following back-to-back word.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit hold);
        bit taken;
        taken = 1'b0;
        din = w;
        din_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (din_ready) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (!hold) din_valid = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with a word offered: nothing may be accepted.
        din = 8'h3C;
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check("rst_x", 32'(x), 32'd0);
        check("rst_x_valid", 32'(x_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_word_done", 32'(word_done), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        mon_en = 1'b1;

        // Single word, then IDLE.
        send_word(8'hA5, 1'b0);
        repeat (12) @(negedge clk);

        // Back-to-back with din_valid held: no bubble between the words.
        send_word(8'hA5, 1'b1);
        send_word(8'h5A, 1'b0);
        repeat (12) @(negedge clk);

        // A new value offered mid-word (and changing) must wait for the final bit.
        send_word(8'hA5, 1'b0);
        din = 8'hFF;
        din_valid = 1'b1;
        repeat (2) @(negedge clk);
        din = 8'h81;
        send_word(8'h3C, 1'b0);
        repeat (12) @(negedge clk);

        // Reset mid-word discards it; the following word starts cleanly at its MSB.
        send_word(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_x_valid", 32'(x_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        send_word(8'h96, 1'b0);
        repeat (12) @(negedge clk);

        // Parity case word plus a short random back-to-back burst.
        send_word(8'h07, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send_word(WIDTH'($urandom), (i != 5));
        end

        begin
            bit drained;
            drained = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(negedge clk);
                if (exp_q.size() == 0 && !x_valid) begin
                    drained = 1'b1;
                    break;
                end
            end
            if (!drained) check("drain_timeout", 32'd0, 32'd1);
        end
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
